// File: rtl/cpu_ad48_core.sv
// Single-cycle 48-bit A/D-bank CPU with private instruction and data memories.
// One instruction retires per clock until a HALT freezes the machine.

module ad48_rom #(
  parameter int WORDS = 128,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] raddr,
  output logic [47:0]   rdata
);
  // Contents come from a backdoor preload; nothing in the design writes it.
  logic [47:0] mem [0:WORDS-1];

  assign rdata = mem[raddr];
endmodule

module ad48_ram #(
  parameter int WORDS = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [47:0]   wdata,
  output logic [47:0]   rdata
);
  logic [47:0] mem [0:WORDS-1];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module ad48_rf (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [47:0]     wdata,
  output logic [7:0][47:0] q
);
  logic [47:0] regs [0:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < 8; i++) q[i] = regs[i];
  end
endmodule

module cpu_ad48_core #(
  parameter int IM_WORDS = 128,
  parameter int DM_WORDS = 32
) (
  input  logic clk,
  input  logic rst,
  output logic halt
);
  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_WORDS);

  localparam logic [3:0] OP_ALU  = 4'd0, OP_ALUI = 4'd1, OP_BR = 4'd2, OP_JAL = 4'd3,
                         OP_JALR = 4'd4, OP_LD   = 4'd5, OP_ST = 4'd6, OP_SYS = 4'd15;

  logic [47:0] pc, pc1, pc_next, ir;
  logic [7:0][47:0] a_q, d_q;
  logic [47:0] wr_val, dm_rdata;
  logic        wr_en, wr_sel, dm_we, halt_set, taken;
  logic        a_we, d_we;
  logic [DAW-1:0] dm_addr;

  logic [3:0]  op;
  logic        sel;
  logic [2:0]  rd, rs, rb;
  logic [47:0] a_rs, d_rs, d_rb, d_rd;
  logic [47:0] imm27, off31, off36, imm33;

  ad48_rom #(.WORDS(IM_WORDS)) IMEM (.raddr(pc[IAW-1:0]), .rdata(ir));

  ad48_rf RF_A (.clk(clk), .rst(rst), .we(a_we), .waddr(rd), .wdata(wr_val), .q(a_q));
  ad48_rf RF_D (.clk(clk), .rst(rst), .we(d_we), .waddr(rd), .wdata(wr_val), .q(d_q));

  ad48_ram #(.WORDS(DM_WORDS)) DMEM (
    .clk(clk), .we(dm_we & ~halt), .addr(dm_addr), .wdata(d_rd), .rdata(dm_rdata)
  );

  assign op    = ir[47:44];
  assign sel   = ir[43];
  assign rd    = ir[42:40];
  assign rs    = ir[39:37];
  assign rb    = ir[36:34];
  assign a_rs  = a_q[rs];
  assign d_rs  = d_q[rs];
  assign d_rb  = d_q[rb];
  assign d_rd  = d_q[rd];
  assign imm27 = {{21{ir[26]}}, ir[26:0]};
  assign off31 = {{17{ir[30]}}, ir[30:0]};
  assign off36 = {{12{ir[35]}}, ir[35:0]};
  assign imm33 = {{15{ir[32]}}, ir[32:0]};
  assign pc1   = pc + 48'd1;
  assign dm_addr = DAW'(a_rs + imm27);

  function automatic logic [47:0] alu(input logic [47:0] x, input logic [47:0] y,
                                      input logic [3:0] f);
    logic [5:0] sh;
    sh = y[5:0];
    case (f)
      4'd0:    alu = x + y;
      4'd1:    alu = x - y;
      4'd2:    alu = x & y;
      4'd3:    alu = x | y;
      4'd4:    alu = x ^ y;
      4'd5:    alu = (sh >= 6'd48) ? '0 : x << sh;
      4'd6:    alu = (sh >= 6'd48) ? '0 : x >> sh;
      4'd7:    alu = (sh >= 6'd48) ? {48{x[47]}} : 48'($signed(x) >>> sh);
      4'd8:    alu = {47'd0, $signed(x) < $signed(y)};
      4'd9:    alu = {47'd0, x < y};
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    case (ir[43:40])
      4'd0:    taken = (a_rs == d_rb);
      4'd1:    taken = (a_rs != d_rb);
      4'd4:    taken = ($signed(a_rs) <  $signed(d_rb));
      4'd5:    taken = ($signed(a_rs) >= $signed(d_rb));
      4'd6:    taken = (a_rs <  d_rb);
      4'd7:    taken = (a_rs >= d_rb);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_sel   = sel;
    wr_val   = '0;
    pc_next  = pc1;
    dm_we    = 1'b0;
    halt_set = 1'b0;
    case (op)
      OP_ALU: begin
        wr_en  = 1'b1;
        wr_val = alu(a_rs, d_rb, ir[33:30]);
      end
      OP_ALUI: begin
        wr_en  = 1'b1;
        wr_val = alu(sel ? d_rs : a_rs, imm27, ir[30:27]);
      end
      OP_BR:   if (taken) pc_next = pc1 + off31;
      OP_JAL: begin
        wr_en   = 1'b1;
        wr_val  = pc1;
        pc_next = pc1 + off36;
      end
      OP_JALR: begin
        // Target uses the pre-write A[rs], so rd==rs links correctly.
        wr_en   = 1'b1;
        wr_val  = pc1;
        pc_next = a_rs + imm33;
      end
      OP_LD: begin
        wr_en  = 1'b1;
        wr_sel = 1'b1;
        wr_val = dm_rdata;
      end
      OP_ST:   dm_we = 1'b1;
      OP_SYS: if (ir[43:40] == 4'hF) begin
        halt_set = 1'b1;
        pc_next  = pc;
      end
      default: ;
    endcase
  end

  // A0 is hardwired zero: writes to it are simply dropped.
  assign a_we = wr_en & ~wr_sel & (rd != 3'd0) & ~halt;
  assign d_we = wr_en & wr_sel & ~halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      halt <= 1'b0;
    end else if (!halt) begin
      pc   <= pc_next;
      halt <= halt_set;
    end
  end
endmodule

// File: tb/tb_cpu_ad48_core.sv
// Program-level bench: each program runs to HALT, then the final architectural
// state is compared with an instruction-level reference model.

module tb_cpu_ad48_core;
  logic clk, rst, halt;

  cpu_ad48_core #(.IM_WORDS(128), .DM_WORDS(32)) dut (.clk(clk), .rst(rst), .halt(halt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][47:0]  a;
    logic [7:0][47:0]  d;
    logic [31:0][47:0] dm;
    logic [47:0]       hpc;
    logic [31:0]       steps;
  } exp_t;

  exp_t sb[$];
  event go_ev, done_ev;
  int n_checks = 0, n_err = 0;

  logic [47:0] prog [128];
  logic [47:0] ma [8], md [8], mdm [32];

  localparam logic [47:0] HALT_W = {4'hF, 4'hF, 40'd0};

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [47:0] e_alu(input logic s, input logic [2:0] d, a, b, input logic [3:0] f);
    return {4'd0, s, d, a, b, f, 30'd0};
  endfunction
  function automatic logic [47:0] e_alui(input logic s, input logic [2:0] d, r, input logic [3:0] f, input logic [26:0] i);
    return {4'd1, s, d, r, 6'd0, f, i};
  endfunction
  function automatic logic [47:0] e_br(input logic [3:0] c, input logic [2:0] a, b, input logic [30:0] o);
    return {4'd2, c, a, b, 3'd0, o};
  endfunction
  function automatic logic [47:0] e_jal(input logic s, input logic [2:0] d, input logic [35:0] o);
    return {4'd3, s, d, 4'd0, o};
  endfunction
  function automatic logic [47:0] e_jalr(input logic s, input logic [2:0] d, r, input logic [32:0] i);
    return {4'd4, s, d, r, 4'd0, i};
  endfunction
  function automatic logic [47:0] e_ld(input logic [2:0] d, r, input logic [26:0] i);
    return {4'd5, 1'b0, d, r, 10'd0, i};
  endfunction
  function automatic logic [47:0] e_st(input logic [2:0] t, r, input logic [26:0] i);
    return {4'd6, 1'b0, t, r, 10'd0, i};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [47:0] sx(input logic [47:0] v, input int bits);
    logic [47:0] m;
    m = (48'd1 << bits) - 48'd1;
    return v[bits-1] ? ((v & m) | ~m) : (v & m);
  endfunction

  function automatic longint s48(input logic [47:0] v);
    return longint'({{16{v[47]}}, v});
  endfunction

  function automatic logic [47:0] ref_alu(input logic [47:0] a, b, input logic [3:0] f);
    int sh;
    sh = int'(b[5:0]);
    case (f)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sh >= 48) ? 48'd0 : a << sh;
      6: return (sh >= 48) ? 48'd0 : a >> sh;
      7: return 48'(s48(a) >>> ((sh >= 48) ? 47 : sh));
      8: return (s48(a) < s48(b)) ? 48'd1 : 48'd0;
      9: return (a < b) ? 48'd1 : 48'd0;
      default: return 48'd0;
    endcase
  endfunction

  task automatic mwr(input logic s, input logic [2:0] r, input logic [47:0] v);
    if (s) md[r] = v;
    else if (r != 0) ma[r] = v;
  endtask

  task automatic model_run(input int limit, output int steps, output logic [47:0] hpc);
    logic [47:0] pc, ir, nxt, x, y;
    logic        hlt, tk;
    for (int i = 0; i < 8; i++) begin ma[i] = 0; md[i] = 0; end
    pc = 0; steps = 0; hlt = 0; hpc = 0;
    while (!hlt && steps < limit) begin
      ir = prog[pc % 128];
      steps++;
      nxt = pc + 1;
      x = ma[ir[39:37]];
      y = md[ir[36:34]];
      case (ir[47:44])
        0: mwr(ir[43], ir[42:40], ref_alu(x, y, ir[33:30]));
        1: mwr(ir[43], ir[42:40], ref_alu(ir[43] ? md[ir[39:37]] : x, sx(48'(ir[26:0]), 27), ir[30:27]));
        2: begin
          case (ir[43:40])
            0: tk = (x == y);
            1: tk = (x != y);
            4: tk = s48(x) <  s48(y);
            5: tk = s48(x) >= s48(y);
            6: tk = x <  y;
            7: tk = x >= y;
            default: tk = 0;
          endcase
          if (tk) nxt = pc + 1 + sx(48'(ir[30:0]), 31);
        end
        3: begin mwr(ir[43], ir[42:40], pc + 1); nxt = pc + 1 + sx(48'(ir[35:0]), 36); end
        4: begin nxt = x + sx(48'(ir[32:0]), 33); mwr(ir[43], ir[42:40], pc + 1); end
        5: md[ir[42:40]] = mdm[(x + sx(48'(ir[26:0]), 27)) % 32];
        6: mdm[(x + sx(48'(ir[26:0]), 27)) % 32] = md[ir[42:40]];
        15: if (ir[43:40] == 4'hF) begin hlt = 1; hpc = pc; nxt = pc; end
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  // ---------------- program helpers ----------------
  task automatic clr_prog();
    for (int i = 0; i < 128; i++) prog[i] = HALT_W;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 128; i++) dut.IMEM.mem[i] = prog[i];
  endtask

  task automatic go();
    exp_t e;
    int st;
    logic [47:0] hp;
    model_run(1000, st, hp);
    for (int i = 0; i < 8; i++) begin e.a[i] = ma[i]; e.d[i] = md[i]; end
    for (int i = 0; i < 32; i++) e.dm[i] = mdm[i];
    e.hpc = hp;
    e.steps = 32'(st);
    sb.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    ->go_ev;
    @done_ev;
  endtask

  task automatic rst_on();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_A%0d", tag, i), dut.RF_A.regs[i], 48'd0);
      chk($sformatf("%s_D%0d", tag, i), dut.RF_D.regs[i], 48'd0);
    end
    chk({tag, "_halt"}, {47'd0, halt}, 48'd0);
    chk({tag, "_pc"}, dut.pc, 48'd0);
  endtask

  task automatic gen_rand();
    int k;
    logic [31:0] r;
    clr_prog();
    k = 0;
    for (int i = 1; i < 8; i++) prog[k++] = e_alui(0, 3'(i), 0, 0, 27'($urandom));
    for (int i = 0; i < 8; i++) prog[k++] = e_alui(1, 3'(i), 3'(i), 0, 27'($urandom));
    while (k < 40) begin
      r = $urandom;
      case ($urandom % 8)
        0: prog[k] = e_alu(r[0], r[3:1], r[6:4], r[9:7], r[13:10]);
        1: prog[k] = e_alui(r[0], r[3:1], r[6:4], r[10:7], 27'($urandom));
        2: prog[k] = e_br(r[3:0], r[6:4], r[9:7], 31'(r[11:10]));
        3: prog[k] = e_jal(r[0], r[3:1], 36'(r[5:4] % 3));
        4: prog[k] = e_jalr(r[0], r[3:1], 0, 33'(k + 1 + (r[5:4] % 3)));
        5: prog[k] = e_ld(r[3:1], r[6:4], 27'($urandom));
        6: prog[k] = e_st(r[3:1], r[6:4], 27'($urandom));
        default: prog[k] = e_alui(r[0], r[3:1], r[6:4], 4'(5 + (r[9:7] % 3)), 27'(r[15:10]));
      endcase
      k++;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    int cyc;
    logic seen;
    forever begin
      @go_ev;
      e = sb[0];
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 2000) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        seen = halt;
      end
      chk("halt_cycle", 48'(cyc), 48'(e.steps));
      repeat (2) @(negedge clk);
      chk("halt_sticky", {47'd0, halt}, 48'd1);
      chk("pc_frozen", dut.pc, e.hpc);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("A%0d", i), dut.RF_A.regs[i], e.a[i]);
        chk($sformatf("D%0d", i), dut.RF_D.regs[i], e.d[i]);
      end
      for (int i = 0; i < 32; i++) chk($sformatf("DM%0d", i), dut.DMEM.mem[i], e.dm[i]);
      void'(sb.pop_front());
      ->done_ev;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Give every data word a defined value first.
    clr_prog();
    for (int i = 0; i < 32; i++) prog[i] = e_st(0, 0, 27'(i));
    load_prog(); go(); rst_on();

    clr_prog();
    prog[0] = e_alui(0, 1, 1, 0, 27'd5);
    prog[1] = e_alui(1, 1, 1, 0, 27'd5);
    prog[2] = e_alui(0, 2, 2, 0, -27'sd7);
    prog[3] = e_alui(1, 2, 2, 0, -27'sd3);
    load_prog(); go();
    chk("alui_A1", dut.RF_A.regs[1], 48'd5);
    chk("alui_A2", dut.RF_A.regs[2], 48'hFFFF_FFFF_FFF9);
    chk("alui_D2", dut.RF_D.regs[2], 48'hFFFF_FFFF_FFFD);
    rst_on();

    clr_prog();
    prog[0]  = e_alui(0, 1, 0, 0, 27'd5);
    prog[1]  = e_alui(1, 1, 1, 0, 27'd5);
    prog[2]  = e_alui(0, 2, 0, 0, -27'sd7);
    prog[3]  = e_alui(1, 2, 2, 0, -27'sd3);
    prog[4]  = e_alui(0, 4, 0, 0, -27'sd1);
    prog[5]  = e_alui(1, 3, 3, 0, 27'd9);
    prog[6]  = e_br(0, 1, 1, 31'd1); prog[7]  = e_alui(1, 4, 4, 0, 27'd1);
    prog[8]  = e_br(1, 1, 1, 31'd1); prog[9]  = e_alui(1, 4, 4, 0, 27'd2);
    prog[10] = e_br(4, 2, 2, 31'd1); prog[11] = e_alui(1, 4, 4, 0, 27'd4);
    prog[12] = e_br(6, 4, 3, 31'd1); prog[13] = e_alui(1, 4, 4, 0, 27'd8);
    prog[14] = e_br(7, 4, 3, 31'd1); prog[15] = e_alui(1, 4, 4, 0, 27'd16);
    prog[16] = e_br(5, 1, 1, 31'd1); prog[17] = e_alui(1, 4, 4, 0, 27'd32);
    load_prog(); go();
    chk("branch_D4", dut.RF_D.regs[4], 48'd10);
    rst_on();

    clr_prog();
    prog[0] = e_alui(0, 5, 0, 0, 27'd2);
    prog[1] = e_alui(0, 5, 5, 0, -27'sd1);
    prog[2] = e_alui(1, 7, 7, 0, 27'd1);
    prog[3] = e_br(1, 5, 0, -31'sd3);
    load_prog(); go();
    chk("loop_A5", dut.RF_A.regs[5], 48'd0);
    chk("loop_D7", dut.RF_D.regs[7], 48'd2);
    rst_on();

    clr_prog();
    prog[0] = e_jal(1, 6, 36'd5);
    prog[1] = e_alui(1, 1, 1, 0, 27'd1);
    prog[2] = e_jal(0, 7, 36'd1);
    prog[3] = e_alui(1, 2, 2, 0, 27'd9);
    prog[6] = e_alu(0, 6, 0, 6, 0);
    prog[7] = e_jalr(0, 0, 6, 33'd0);
    load_prog(); go();
    chk("call_D6", dut.RF_D.regs[6], 48'd1);
    chk("call_A7", dut.RF_A.regs[7], 48'd3);
    chk("call_D1", dut.RF_D.regs[1], 48'd1);
    chk("call_skip_D2", dut.RF_D.regs[2], 48'd0);
    chk("call_A0", dut.RF_A.regs[0], 48'd0);
    rst_on();

    clr_prog();
    prog[0] = e_alui(0, 1, 0, 0, 27'd3);
    prog[1] = e_alui(1, 2, 0, 0, 27'h123456);
    prog[2] = e_alui(1, 2, 2, 5, 27'd24);
    prog[3] = e_alui(1, 2, 2, 3, 27'h789ABC);
    prog[4] = e_st(2, 1, 27'd1);
    prog[5] = e_ld(3, 1, 27'd1);
    load_prog(); go();
    chk("ldst_D3", dut.RF_D.regs[3], 48'h1234_5678_9ABC);
    rst_on();

    for (int t = 0; t < 8; t++) begin
      gen_rand(); load_prog(); go(); rst_on();
    end

    // Reset in the middle of a run, then a full rerun from PC 0.
    begin
      int st;
      logic [47:0] hp;
      gen_rand(); load_prog();
      model_run(3, st, hp);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("midrst");
      @(negedge clk);
      go();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_ad48_core.md
Name: cpu_ad48_core

Overview:
- Single-cycle 48-bit CPU with two 8-entry register banks: A (address) and D (data).
- Contains a word-addressed instruction memory and data memory, and executes one instruction per clock.
- Top-level processor block; programs are preloaded into the instruction memory by backdoor.
- Stops permanently on a HALT instruction.

Parameters:
- IM_WORDS, 128, instruction memory depth in 48-bit words (power of 2).
- DM_WORDS, 32, data memory depth in 48-bit words (power of 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- halt  out  1  sticky high once HALT has executed.

Behaviour:
- Internal hierarchy: instruction array IMEM.mem[0:IM_WORDS-1], register arrays RF_A.regs[0:7] and RF_D.regs[0:7], data array DMEM.mem[0:DM_WORDS-1], all 48-bit.
- Reset (async, rst=1):
  - PC=0 and halt=0.
  - All RF_A/RF_D entries cleared to 0.
  - IMEM and DMEM are not cleared.
- PC counts in words. Fetch uses IMEM[PC mod IM_WORDS]; DMEM index is addr mod DM_WORDS.
- Each clock while not halted, the instruction executes completely: one register write, PC update. Latency 1 cycle.
- A0 always reads 0 and writes to it are discarded. D0 is an ordinary register.
- All-zero word = ALU A0=A0+D0, i.e. a NOP.
- Encoding: op=[47:44]. imm/offset fields are two's complement, sign-extended to 48 bits. Unused bits are 0.
- op 0, ALU reg:
  - Fields: sel=[43] (0 writes A, 1 writes D), rd=[42:40], ra=[39:37] (A bank), rb=[36:34] (D bank), func=[33:30], [29] reserved/ignored.
  - Result = A[ra] func D[rb].
- op 1, ALUI:
  - Fields: sel=[43], rd=[42:40], rs=[39:37] (same bank as sel), func=[30:27], imm27=[26:0].
  - Result = R[rs] func sext(imm27).
- func codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR, 7 SRA; shift amount = low 6 bits of the second operand, amounts >=48 give 0 (sign fill for SRA).
  - 8 SLT, 9 SLTU; result 1 or 0.
  - Other codes give 0. Arithmetic wraps modulo 2^48.
- op 2, BR:
  - Fields: cond=[43:40], ra=[39:37] (A bank), rb=[36:34] (D bank), off31=[30:0].
  - Compares A[ra] against D[rb]. If true, PC = PC+1+sext(off31); else PC+1.
  - cond: 0 BEQ, 1 BNE, 4 BLT, 5 BGE (signed), 6 BLTU, 7 BGEU (unsigned). Other codes are never taken.
- op 3, JAL:
  - Fields: sel=[43], rd=[42:40], off36=[35:0].
  - Link: bank(sel)[rd] = PC+1. Then PC = PC+1+sext(off36).
- op 4, JALR:
  - Fields: sel=[43], rd=[42:40], rs=[39:37] (A bank), imm33=[32:0].
  - Target = A[rs]+sext(imm33), computed from pre-write register values. Link = PC+1, written to bank(sel)[rd].
- op 5, LD: D[rd=[42:40]] = DMEM[A[rs=[39:37]]+sext(imm27)].
- op 6, ST: DMEM[A[rs]+sext(imm27)] = D[rt=[42:40]].
- op 15, SYS, code=[43:40]:
  - 0xF HALT: halt=1 at that clock edge; PC frozen; no further register or memory writes until reset.
  - Other codes are NOP.
- Undefined opcodes are NOPs (PC+1).
- Register reads are combinational. Writes occur on the rising edge. A read of a register written by the previous instruction sees the new value.

Test Plan:
- Reset, then ALUI A1+=5, D1+=5, A2+=-7, D2+=-3, then HALT -> A1=5, D1=5, A2=0xFFFFFFFFFFF9, D2=0xFFFFFFFFFFFD, halt=1, PC frozen.
- Branch conditions, each followed by an increment:
  - A1=5/D1=5: BEQ taken, BNE falls through.
  - A2=-7/D2=-3: BLT taken.
  - A4=-1/D3=9: BLTU not taken, BGEU taken.
  - A1=5/D1=5: BGE taken.
  - Only non-skipped increments land.
- Loop: A5=2; body A5-=1, D7+=1; BNE A5,D0(=0) back -> body runs twice, D7 increases by 2, A5=0.
- Call/return:
  - JAL sel=1 rd=6 at index k -> D6=k+1.
  - Subroutine A6=A0+D6, then JALR rd=A0 rs=A6 imm 0 -> returns to k+1; A0 stays 0.
  - JAL sel=0 rd=7 skips one instruction -> A7 = index+1, skipped write absent.
- LD/ST: A1=3, D2=0x123456789ABC; ST [A1+1],D2; LD D3,[A1+1] -> D3=0x123456789ABC.
- Assert rst mid-program -> PC, halt and all registers return to 0 asynchronously; execution restarts at 0 after release.
